// File: rtl/dbg_scan_slave_if.sv
// Scan-side and CPU-side signal bundle for the debug scan slave.
// The slave modport is the scan slave itself; the master modport is the scan/CPU side driving it.
interface dbg_scan_slave_if #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                               scan_en;
  logic                               cdr;
  logic                               sdr;
  logic                               udr;
  logic                               uir;
  logic [IR_WIDTH-1:0]                ir_in;
  logic                               tdi;
  logic [DR_WIDTH*(2**IR_WIDTH)-1:0]  capture_data;
  logic                               err_clr;
  logic                               act_ready;
  logic                               tdo;
  logic [IR_WIDTH-1:0]                ir_out;
  logic [DR_WIDTH-1:0]                jdo;
  logic                               act_valid;
  logic                               act_take;
  logic [IR_WIDTH-1:0]                act_ch;

  modport slave (
    input  scan_en, cdr, sdr, udr, uir, ir_in, tdi, capture_data, err_clr, act_ready,
    output tdo, ir_out, jdo, act_valid, act_take, act_ch
  );

  modport master (
    output scan_en, cdr, sdr, udr, uir, ir_in, tdi, capture_data, err_clr, act_ready,
    input  tdo, ir_out, jdo, act_valid, act_take, act_ch
  );
endinterface

// File: rtl/dbg_scan_slave.sv
// Debug scan slave: captures a per-channel status word, shifts it out while a command shifts in,
// and on update presents the command to the CPU side through a valid/ready handshake.
module dbg_scan_slave #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  dbg_scan_slave_if.slave    s
);
  localparam int                CNT_W    = $clog2(DR_WIDTH + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DR_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(DR_WIDTH + 1);

  logic [IR_WIDTH-1:0] r_ir;
  logic [DR_WIDTH-1:0] r_sr;
  logic [CNT_W-1:0]    r_cnt;
  logic [DR_WIDTH-1:0] r_jdo;
  logic                r_act_valid;
  logic                r_act_take;
  logic [IR_WIDTH-1:0] r_act_ch;
  logic                r_scan_err;
  logic                r_overrun;

  logic                w_xfer;
  logic                w_uir;
  logic                w_udr;
  logic                w_cdr;
  logic                w_sdr;
  logic                w_len_ok;
  logic                w_accept;
  logic                w_scan_err_set;
  logic                w_overrun_set;
  logic [DR_WIDTH-1:0] w_cap_word;
  logic [IR_WIDTH-1:0] w_ir_out;

  // Only the highest-priority scan event of the cycle is honoured: uir > udr > cdr > sdr.
  assign w_uir = s.uir;
  assign w_udr = s.udr & ~s.uir;
  assign w_cdr = s.cdr & s.scan_en & ~s.uir & ~s.udr;
  assign w_sdr = s.sdr & s.scan_en & ~s.uir & ~s.udr & ~s.cdr;

  assign w_xfer         = r_act_valid & s.act_ready;
  assign w_len_ok       = (r_cnt == CNT_FULL);
  assign w_scan_err_set = w_udr & ~w_len_ok;
  // A transfer completing this cycle frees the slot, so the update lands instead of overrunning.
  assign w_overrun_set  = w_udr & w_len_ok & r_act_valid & ~w_xfer;
  assign w_accept       = w_udr & w_len_ok & ~(r_act_valid & ~w_xfer);
  assign w_cap_word     = s.capture_data[int'(r_ir) * DR_WIDTH +: DR_WIDTH];

  // NOTE: async reset clears every register, so a reset mid-scan can never leak a stale action.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir  <= '0;
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (w_uir) begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values of its peers.
      r_ir  <= s.ir_in;
      r_cnt <= '0;
    end else if (w_cdr) begin
      r_sr  <= w_cap_word;
      r_cnt <= '0;
    end else if (w_sdr) begin
      r_sr  <= {s.tdi, r_sr[DR_WIDTH-1:1]};
      if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_jdo       <= '0;
      r_act_valid <= 1'b0;
      r_act_take  <= 1'b0;
      r_act_ch    <= '0;
    end else if (w_accept) begin
      r_jdo       <= r_sr;
      r_act_valid <= 1'b1;
      r_act_take  <= r_sr[DR_WIDTH-1];
      r_act_ch    <= r_ir;
    end else if (w_xfer) begin
      r_act_valid <= 1'b0;
    end
  end

  // A flag being set in the same cycle takes precedence over err_clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_err <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_scan_err_set)  r_scan_err <= 1'b1;
      else if (s.err_clr)  r_scan_err <= 1'b0;
      if (w_overrun_set)   r_overrun  <= 1'b1;
      else if (s.err_clr)  r_overrun  <= 1'b0;
    end
  end

  always_comb begin
    w_ir_out    = '0;
    w_ir_out[1] = r_overrun;
    w_ir_out[0] = r_scan_err;
  end

  assign s.tdo       = r_sr[0];
  assign s.ir_out    = w_ir_out;
  assign s.jdo       = r_jdo;
  assign s.act_valid = r_act_valid;
  assign s.act_take  = r_act_take;
  assign s.act_ch    = r_act_ch;
endmodule

// File: tb/tb_dbg_scan_slave.sv
// Directed bench for dbg_scan_slave (DR_WIDTH=38, IR_WIDTH=2): capture/shift, handshake,
// scan-length errors, overrun, update-at-transfer, event priority and asynchronous reset.
module tb_dbg_scan_slave;
  localparam int DW = 38;
  localparam int IW = 2;

  localparam logic [DW-1:0] CH0 = 38'h01_2345_6789;
  localparam logic [DW-1:0] CH1 = 38'h13_3C3C_3C3D;
  localparam logic [DW-1:0] CH2 = 38'h2A_5A5A_5A5A;
  localparam logic [DW-1:0] CH3 = 38'h3F_FFFF_0000;
  localparam logic [DW-1:0] W_TAKE = 38'h20_0000_0001;
  localparam logic [DW-1:0] W5 = 38'h25_1234_5678;
  localparam logic [DW-1:0] W7 = 38'h2A_AAAA_AAAB;
  localparam logic [DW-1:0] W8 = 38'h00_0000_00F0;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  dbg_scan_slave_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) bus ();

  dbg_scan_slave #(.DR_WIDTH(DW), .IR_WIDTH(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after a rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cdr();
    bus.scan_en = 1'b1; bus.cdr = 1'b1;
    step();
    bus.scan_en = 1'b0; bus.cdr = 1'b0;
  endtask

  task automatic do_shift(input logic b);
    bus.scan_en = 1'b1; bus.sdr = 1'b1; bus.tdi = b;
    step();
    bus.scan_en = 1'b0; bus.sdr = 1'b0; bus.tdi = 1'b0;
  endtask

  task automatic do_udr();
    bus.udr = 1'b1;
    step();
    bus.udr = 1'b0;
  endtask

  task automatic do_err_clr();
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
  endtask

  task automatic scan_n(input logic [DW-1:0] w, input int n);
    do_cdr();
    for (int i = 0; i < n; i++) do_shift((i < DW) ? w[i] : 1'b0);
  endtask

  initial begin
    logic [DW-1:0] stream;

    reset = 1'b1;
    bus.scan_en = 1'b0; bus.cdr = 1'b0; bus.sdr = 1'b0; bus.udr = 1'b0; bus.uir = 1'b0;
    bus.ir_in = '0; bus.tdi = 1'b0; bus.err_clr = 1'b0; bus.act_ready = 1'b0;
    bus.capture_data = {CH3, CH2, CH1, CH0};
    step();
    step();
    check("rst_tdo", 64'(bus.tdo), 64'd0);
    check("rst_ir_out", 64'(bus.ir_out), 64'd0);
    check("rst_jdo", 64'(bus.jdo), 64'd0);
    check("rst_valid", 64'(bus.act_valid), 64'd0);
    check("rst_take", 64'(bus.act_take), 64'd0);
    check("rst_ch", 64'(bus.act_ch), 64'd0);
    reset = 1'b0;
    step();

    // Capture channel 2 and stream it out LSB first with zeros shifted in.
    bus.uir = 1'b1; bus.ir_in = 2'd2;
    step();
    bus.uir = 1'b0;
    do_cdr();
    for (int i = 0; i < DW; i++) begin
      stream[i] = bus.tdo;
      do_shift(1'b0);
    end
    check("cap_stream", 64'(stream), 64'(CH2));
    check("cap_tdo_end", 64'(bus.tdo), 64'd0);
    bus.act_ready = 1'b1;
    do_udr();
    check("sr_zero_jdo", 64'(bus.jdo), 64'd0);
    check("sr_zero_valid", 64'(bus.act_valid), 64'd1);
    step();
    check("sr_zero_done", 64'(bus.act_valid), 64'd0);

    // Take-action command, act_ready held high.
    scan_n(W_TAKE, DW);
    do_udr();
    check("take_jdo", 64'(bus.jdo), 64'(W_TAKE));
    check("take_take", 64'(bus.act_take), 64'd1);
    check("take_ch", 64'(bus.act_ch), 64'd2);
    check("take_valid", 64'(bus.act_valid), 64'd1);
    step();
    check("take_valid_1cyc", 64'(bus.act_valid), 64'd0);
    check("take_jdo_hold", 64'(bus.jdo), 64'(W_TAKE));

    // Scan length too short, then too long.
    scan_n(38'h3, DW - 1);
    do_udr();
    check("short_ir_out", 64'(bus.ir_out), 64'd1);
    check("short_jdo", 64'(bus.jdo), 64'(W_TAKE));
    check("short_valid", 64'(bus.act_valid), 64'd0);
    do_err_clr();
    check("short_clr", 64'(bus.ir_out), 64'd0);
    scan_n(38'h3, DW + 1);
    do_udr();
    check("long_ir_out", 64'(bus.ir_out), 64'd1);
    check("long_jdo", 64'(bus.jdo), 64'(W_TAKE));
    check("long_valid", 64'(bus.act_valid), 64'd0);
    do_err_clr();
    check("long_clr", 64'(bus.ir_out), 64'd0);

    // Overrun: second update while the first is still pending.
    bus.act_ready = 1'b0;
    scan_n(38'h1, DW);
    do_udr();
    check("ovr_first_valid", 64'(bus.act_valid), 64'd1);
    scan_n(38'h2, DW);
    do_udr();
    check("ovr_jdo", 64'(bus.jdo), 64'h1);
    check("ovr_ir_out", 64'(bus.ir_out), 64'd2);
    check("ovr_valid", 64'(bus.act_valid), 64'd1);
    bus.act_ready = 1'b1;
    step();
    check("ovr_xfer_done", 64'(bus.act_valid), 64'd0);
    check("ovr_jdo_kept", 64'(bus.jdo), 64'h1);
    step();
    check("ovr_no_second", 64'(bus.act_valid), 64'd0);
    do_err_clr();
    check("ovr_clr", 64'(bus.ir_out), 64'd0);

    // Update lands in the same cycle as a completing transfer.
    bus.act_ready = 1'b0;
    scan_n(38'h3, DW);
    do_udr();
    check("upd_first_jdo", 64'(bus.jdo), 64'h3);
    scan_n(W5, DW);
    bus.act_ready = 1'b1; bus.udr = 1'b1;
    step();
    bus.act_ready = 1'b0; bus.udr = 1'b0;
    check("upd_valid", 64'(bus.act_valid), 64'd1);
    check("upd_jdo", 64'(bus.jdo), 64'(W5));
    check("upd_take", 64'(bus.act_take), 64'd1);
    check("upd_no_ovr", 64'(bus.ir_out), 64'd0);
    bus.act_ready = 1'b1;
    step();
    check("upd_done", 64'(bus.act_valid), 64'd0);

    // uir and udr together: only the IR changes.
    bus.act_ready = 1'b0;
    scan_n(38'h15, DW);
    bus.uir = 1'b1; bus.ir_in = 2'd1; bus.udr = 1'b1;
    step();
    bus.uir = 1'b0; bus.udr = 1'b0;
    check("prio_valid", 64'(bus.act_valid), 64'd0);
    check("prio_jdo", 64'(bus.jdo), 64'(W5));
    check("prio_ir_out", 64'(bus.ir_out), 64'd0);
    do_cdr();
    check("prio_ch1_bit0", 64'(bus.tdo), 64'(CH1[0]));
    do_shift(1'b0);
    check("prio_ch1_bit1", 64'(bus.tdo), 64'(CH1[1]));

    // Pending action, sticky error and a partial shift, then asynchronous reset.
    scan_n(W7, DW);
    do_udr();
    check("pre_rst_valid", 64'(bus.act_valid), 64'd1);
    check("pre_rst_ch", 64'(bus.act_ch), 64'd1);
    scan_n(38'h0, 5);
    do_udr();
    check("pre_rst_err", 64'(bus.ir_out), 64'd1);
    check("pre_rst_tdo", 64'(bus.tdo), 64'(CH1[5]));
    #2;
    reset = 1'b1;
    #1;
    check("arst_tdo", 64'(bus.tdo), 64'd0);
    check("arst_ir_out", 64'(bus.ir_out), 64'd0);
    check("arst_jdo", 64'(bus.jdo), 64'd0);
    check("arst_valid", 64'(bus.act_valid), 64'd0);
    check("arst_take", 64'(bus.act_take), 64'd0);
    check("arst_ch", 64'(bus.act_ch), 64'd0);
    step();
    reset = 1'b0;
    step();
    check("post_rst_valid", 64'(bus.act_valid), 64'd0);
    do_cdr();
    check("post_rst_ch0", 64'(bus.tdo), 64'(CH0[0]));
    bus.act_ready = 1'b1;
    scan_n(W8, DW);
    do_udr();
    check("post_rst_jdo", 64'(bus.jdo), 64'(W8));
    check("post_rst_ch", 64'(bus.act_ch), 64'd0);
    check("post_rst_take", 64'(bus.act_take), 64'd0);
    check("post_rst_valid1", 64'(bus.act_valid), 64'd1);
    step();
    check("post_rst_done", 64'(bus.act_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
